// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for a four-digit
// seven-segment display. It steps the digit select at a fixed refresh rate,
// loads new digit values only at frame boundaries (tear-free), and blinks
// selected digits. It also blanks a leading zero and invalid BCD values.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   digits_in    staged digits, [15:12] = sel 0 (leftmost) .. [3:0] = sel 3
//   load         one-cycle strobe capturing digits_in into the pending register
//   blink_mask   bit i set = digit at sel i blinks
//   colon_en     enable the dot at sel 1 (follows the blink phase)
//   lz_en        blank digit sel 0 when its value is 0
//   busy         pending value not yet committed
//   sel          digit select to the decoder
//   bcd          BCD nibble to the decoder
//   dot_req      dot request to the decoder
//   blank        current digit dark
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_TICKS = 250,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic [3:0]  blink_mask,
  input  logic        colon_en,
  input  logic        lz_en,
  output logic        busy,
  output logic [1:0]  sel,
  output logic [3:0]  bcd,
  output logic        dot_req,
  output logic        blank
);

  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [15:0]        committed_q, committed_d;
  logic [15:0]        pending_q, pending_d;
  logic               busy_q, busy_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         bcd_q, bcd_d;
  logic               dot_q, dot_d;
  logic               blank_q, blank_d;

  logic               tick_c;
  logic               frame_c;
  logic [3:0]         val_c;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      committed_q   <= '0;
      pending_q     <= '0;
      busy_q        <= 1'b0;
      sel_q         <= '0;
      bcd_q         <= '0;
      dot_q         <= 1'b0;
      blank_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      committed_q   <= committed_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      sel_q         <= sel_d;
      bcd_q         <= bcd_d;
      dot_q         <= dot_d;
      blank_q       <= blank_d;
    end
  end

  // Next-state: prescaler, scan, load handshake, blink and slot outputs
  always_comb begin
    cnt_d         = cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    committed_d   = committed_q;
    pending_d     = pending_q;
    busy_d        = busy_q;
    sel_d         = sel_q;
    bcd_d         = bcd_q;
    dot_d         = dot_q;
    blank_d       = blank_q;
    val_c         = '0;

    tick_c  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_c = tick_c && (sel_q == 2'd3);

    cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);

    if (load) begin
      pending_d = digits_in;
      busy_d    = 1'b1;
    end

    // A load on the boundary edge bypasses pending and commits directly
    if (frame_c) begin
      if (load) begin
        committed_d = digits_in;
        busy_d      = 1'b0;
      end else if (busy_q) begin
        committed_d = pending_q;
        busy_d      = 1'b0;
      end
    end

    if (tick_c) begin
      sel_d = sel_q + 2'd1;
      if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    // Slot outputs reflect the new sel and the post-commit state
    case (sel_d)
      2'd0:    val_c = committed_d[15:12];
      2'd1:    val_c = committed_d[11:8];
      2'd2:    val_c = committed_d[7:4];
      default: val_c = committed_d[3:0];
    endcase

    if (tick_c) begin
      bcd_d   = val_c;
      blank_d = (blink_mask[sel_d] & ~blink_phase_d)
              | ((sel_d == 2'd0) & lz_en & (val_c == 4'd0))
              | (val_c > 4'd9);
      dot_d   = colon_en & blink_phase_d & (sel_d == 2'd1);
    end
  end

  assign busy    = busy_q;
  assign sel     = sel_q;
  assign bcd     = bcd_q;
  assign dot_req = dot_q;
  assign blank   = blank_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with REFRESH_DIV=4, BLINK_TICKS=8.
// Each table record is one digit slot: enables, an optional load at a clock
// offset inside the slot, and the outputs expected right after the tick edge.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic        load;
  logic [3:0]  blink_mask;
  logic        colon_en;
  logic        lz_en;
  logic        busy;
  logic [1:0]  sel;
  logic [3:0]  bcd;
  logic        dot_req;
  logic        blank;

  int total = 0;
  int bad   = 0;

  display_scan_ctrl #(.REFRESH_DIV(4), .BLINK_TICKS(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
    .blink_mask(blink_mask), .colon_en(colon_en), .lz_en(lz_en),
    .busy(busy), .sel(sel), .bcd(bcd), .dot_req(dot_req), .blank(blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic        colon;
    logic        lz;
    logic        ld;
    int unsigned ld_at;
    logic [15:0] ld_val;
    logic [1:0]  e_sel;
    logic [3:0]  e_bcd;
    logic        e_blank;
    logic        e_dot;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] bcd;
    logic       blank;
    logic       dot;
    logic       busy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t v(input logic [3:0] m, input logic c, input logic z,
                             input logic ld, input int unsigned at, input logic [15:0] val,
                             input logic [1:0] s, input logic [3:0] b, input logic bl,
                             input logic d, input logic bz);
    vec_t r;
    r.mask = m; r.colon = c; r.lz = z; r.ld = ld; r.ld_at = at; r.ld_val = val;
    r.e_sel = s; r.e_bcd = b; r.e_blank = bl; r.e_dot = d; r.e_busy = bz;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pop the oldest expected slot and compare all outputs
  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".sel"},   16'(sel),     16'(e.sel));
      check({tag, ".bcd"},   16'(bcd),     16'(e.bcd));
      check({tag, ".blank"}, 16'(blank),   16'(e.blank));
      check({tag, ".dot"},   16'(dot_req), 16'(e.dot));
      check({tag, ".busy"},  16'(busy),    16'(e.busy));
    end
  endtask

  // One slot: four clock edges, the last of which is the tick
  task automatic run_vec(input vec_t t, input string tag);
    exp_t e;
    blink_mask = t.mask;
    colon_en   = t.colon;
    lz_en      = t.lz;
    e.sel = t.e_sel; e.bcd = t.e_bcd; e.blank = t.e_blank; e.dot = t.e_dot; e.busy = t.e_busy;
    sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (t.ld && (t.ld_at == k)) begin
        load      = 1'b1;
        digits_in = t.ld_val;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
    end
    check_out(tag);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; digits_in = '0;
    blink_mask = '0; colon_en = 1'b0; lz_en = 1'b0;

    //             mask c  z  ld at val       sel bcd   bl d  busy
    // idle frame after reset
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 0, 0, 0)); // t1
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 2, 4'h0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 3, 4'h0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 0)); // t4
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 0, 0, 0));
    // load 0x1234 while sel=1, committed at the 3->0 tick
    tbl.push_back(v(0, 0, 0, 1, 1, 16'h1234, 2, 4'h0, 0, 0, 1)); // t6
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 3, 4'h0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 0, 4'h1, 0, 0, 0)); // t8
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 1, 4'h2, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 2, 4'h3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 3, 4'h4, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 0, 4'h1, 0, 0, 0)); // t12
    // two loads in one frame, last wins, leading zero blanked
    tbl.push_back(v(0, 0, 0, 1, 0, 16'h1111, 1, 4'h2, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 1, 2, 16'h0959, 2, 4'h3, 0, 0, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 16'h0000, 3, 4'h4, 0, 0, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 16'h0000, 0, 4'h0, 1, 0, 0)); // t16
    tbl.push_back(v(0, 0, 1, 0, 0, 16'h0000, 1, 4'h9, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 16'h0000, 2, 4'h5, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 16'h0000, 3, 4'h9, 0, 0, 0));
    // load on the boundary edge commits directly
    tbl.push_back(v(0, 0, 1, 1, 3, 16'h5678, 0, 4'h5, 0, 0, 0)); // t20
    // invalid BCD digit at sel 2
    tbl.push_back(v(0, 0, 0, 1, 0, 16'h12A4, 1, 4'h6, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 2, 4'h7, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 3, 4'h8, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 0, 4'h1, 0, 0, 0)); // t24 phase->0
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 1, 4'h2, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 2, 4'hA, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 16'h0000, 3, 4'h4, 0, 0, 0));
    // blink sel 0/1 with colon; phase 0 until t32, 1 until t40, then 0
    tbl.push_back(v(3, 1, 0, 1, 3, 16'h1234, 0, 4'h1, 1, 0, 0)); // t28
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 1, 4'h2, 1, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 2, 4'h3, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 3, 4'h4, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 0, 4'h1, 0, 0, 0)); // t32 phase->1
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 1, 4'h2, 0, 1, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 2, 4'h3, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 3, 4'h4, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 0, 4'h1, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 1, 4'h2, 0, 1, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 2, 4'h3, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 3, 4'h4, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 0, 4'h1, 1, 0, 0)); // t40 phase->0
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 1, 4'h2, 1, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 2, 4'h3, 0, 0, 0));
    tbl.push_back(v(3, 1, 0, 0, 0, 16'h0000, 3, 4'h4, 0, 0, 0));

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst.sel",   16'(sel),     16'h0);
    check("rst.bcd",   16'(bcd),     16'h0);
    check("rst.blank", 16'(blank),   16'h0);
    check("rst.dot",   16'(dot_req), 16'h0);
    check("rst.busy",  16'(busy),    16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i + 1));

    // Mid-frame reset with a pending value
    blink_mask = '0; colon_en = 1'b0; lz_en = 1'b0;
    load = 1'b1; digits_in = 16'h9999;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("pre_rst.busy", 16'(busy), 16'h1);
    check("pre_rst.bcd",  16'(bcd),  16'h4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst.sel",   16'(sel),     16'h0);
    check("async_rst.bcd",   16'(bcd),     16'h0);
    check("async_rst.blank", 16'(blank),   16'h0);
    check("async_rst.dot",   16'(dot_req), 16'h0);
    check("async_rst.busy",  16'(busy),    16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Pending 0x9999 must never appear after reset
    run_vec(v(0, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 0, 0, 0), "post_rst1");
    run_vec(v(0, 0, 0, 0, 0, 16'h0000, 2, 4'h0, 0, 0, 0), "post_rst2");
    run_vec(v(0, 0, 0, 0, 0, 16'h0000, 3, 4'h0, 0, 0, 0), "post_rst3");
    run_vec(v(0, 0, 0, 0, 0, 16'h0000, 0, 4'h0, 0, 0, 0), "post_rst4");
    run_vec(v(0, 0, 0, 0, 0, 16'h0000, 1, 4'h0, 0, 0, 0), "post_rst5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for the four-digit seven-segment display.
- Drives the shared BCD-to-segment decoder: digit select, BCD nibble and dot request, one digit at a time, at a fixed refresh rate.
- Adds tear-free frame-boundary loading of new digit values, per-digit blinking for alarm/time-set modes, leading-zero blanking and invalid-BCD blanking.
- Sits between the clock/alarm core and the segment decoder; the top level gates the anodes with blank.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz digit rate at 100 MHz); minimum 2.
- BLINK_TICKS, 250: refresh ticks per blink half-period; minimum 1.
- CNT_W, 17: prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- digits_in  in  16  staged digits; [15:12]=digit sel 0 (leftmost, hours tens) … [3:0]=digit sel 3 (rightmost, minutes units).
- load  in  1  one-cycle strobe: capture digits_in into pending register.
- blink_mask  in  4  bit i set = digit at sel i blinks.
- colon_en  in  1  enable the dot at sel 1 (blinks with the blink phase).
- lz_en  in  1  blank digit sel 0 when its value is 0.
- busy  out  1  pending value not yet committed.
- sel  out  2  digit select to decoder.
- bcd  out  4  BCD nibble to decoder.
- dot_req  out  1  dot request to decoder (active high).
- blank  out  1  1 = current digit dark; top level forces all anodes off.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - prescaler 0, blink counter 0, blink_phase 1 (visible).
  - committed digits 0x0000, pending 0x0000, busy 0.
  - sel 0, bcd 0, dot_req 0, blank 0.
- Prescaler: counts 0..REFRESH_DIV-1. tick asserts for one cycle when count == REFRESH_DIV-1; the count then wraps to 0.
- Scan: on each tick, sel advances 0→1→2→3→0. A frame is 4 ticks. The frame boundary is the tick where sel goes 3→0.
- Registered outputs: sel, bcd, dot_req and blank all update on the same edge as the tick. They are computed from the new sel, the committed digits and state after that edge's commit. No combinational path from inputs to outputs.
- Load handshake:
  - A load in any cycle copies digits_in to pending and sets busy.
  - A load while busy overwrites pending (last wins).
  - At the frame-boundary tick, if busy, pending goes to committed, busy clears, and sel 0 of the new frame already shows the new value.
  - Load coincident with the frame-boundary tick: the new digits_in is committed on that edge directly and busy stays 0.
- Blink:
  - Blink counter counts ticks 0..BLINK_TICKS-1.
  - At the wrap, blink_phase toggles.
  - The blink counter advances only on tick.
- Blank rule for the digit at new sel s, value v: blank = 1 if any of the following holds:
  - (blink_mask[s] & ~blink_phase);
  - (s==0 & lz_en & v==0);
  - (v > 9).
- bcd: outputs v even when blanked.
- Dot: dot_req = colon_en & blink_phase & (sel==1); 0 at all other sels.
- Mask and enables: blink_mask, colon_en and lz_en are sampled on tick only. Changes between ticks have no effect until the next slot.
- Mid-operation reset: everything returns to reset values immediately; pending data is lost.

Test Plan:
- Reset, REFRESH_DIV=4, BLINK_TICKS=8: sel steps 0,1,2,3,0 every 4 clk; with digits 0x0000 loaded, bcd=0 and blank=0 in every slot; busy=0.
- load 0x1234 with sel=1: busy=1 until the tick where sel 3→0. Then bcd sequence 1,2,3,4, and busy=0 on that edge. The 0x0000 frame completes without tearing.
- Two loads, 0x1111 then 0x0959, within one frame: only 0x0959 is shown. With lz_en=1, sel 0 has blank=1 and bcd=0; the other digits are visible.
- blink_mask=4'b0011, colon_en=1: for 8 ticks sel 0/1 are visible and dot_req=1 at sel 1. For the next 8 ticks sel 0/1 have blank=1 and dot_req=0; sel 2/3 are always visible.
- Committed digit 0xA at sel 2 (digits 0x12A4) -> blank=1 at sel 2, bcd=0xA; other digits unaffected.
- rst_n low mid-frame with busy=1 -> sel, bcd, blank, dot_req and busy drop to 0 immediately, asynchronously. After release, the display shows 0000 and the previous pending value is never shown.
